// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out an 8-bit change amount as 10/5/1-unit coins using a greedy choice
// limited by the hopper tube empty flags. One coin is requested at a time and
// must be acknowledged by the hopper. Every coin request is followed by at
// least one low cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, change_in    payout request and amount (accepted only in IDLE)
//   empty10/5/1         tube empty flags, looked at only when choosing a coin
//   hopper_ack          hopper ejected the requested coin
//   clear_fault         leave FAULT
//   coin_req, coin_sel  coin request and denomination (0=1, 1=5, 2=10)
//   busy, done, fault   status (done is a one-cycle pulse)
//   fault_code          01 shortfall, 10 ack timeout, 00 none
//   remaining           amount not yet dispensed
//   cnt10/5/1           coins dispensed per denomination in this payout
// All outputs come straight from flops. Status flops are loaded from the
// next state, so they change on the same edge as the state itself.
// ---------------------------------------------------------------------------
module change_dispenser (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] change_in,
    input  logic       empty10,
    input  logic       empty5,
    input  logic       empty1,
    input  logic       hopper_ack,
    input  logic       clear_fault,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] remaining,
    output logic [7:0] cnt10,
    output logic [7:0] cnt5,
    output logic [7:0] cnt1
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_1  = 2'd0;
    localparam logic [1:0] SEL_5  = 2'd1;
    localparam logic [1:0] SEL_10 = 2'd2;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_SHORTFALL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT   = 2'b10;

    // Unit value of a coin_sel encoding.
    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        logic [7:0] v;
        case (sel)
            SEL_1:   v = 8'd1;
            SEL_5:   v = 8'd5;
            SEL_10:  v = 8'd10;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] ack_tmr_q, ack_tmr_d;
    logic       coin_req_q, coin_req_d;
    logic [1:0] coin_sel_q, coin_sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] cnt10_q, cnt10_d;
    logic [7:0] cnt5_q, cnt5_d;
    logic [7:0] cnt1_q, cnt1_d;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ack_tmr_d    = ack_tmr_q;
        coin_sel_d   = coin_sel_q;
        fault_code_d = fault_code_q;
        remaining_d  = remaining_q;
        cnt10_d      = cnt10_q;
        cnt5_d       = cnt5_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero request also starts a fresh (empty) payout.
                    remaining_d = change_in;
                    cnt10_d     = 8'd0;
                    cnt5_d      = 8'd0;
                    cnt1_d      = 8'd0;
                    if (change_in != 8'd0) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // Greedy: largest stocked coin not exceeding remaining, so
                // remaining can never underflow.
                if (remaining_q == 8'd0) begin
                    state_d = ST_DONE;
                end else if (remaining_q >= 8'd10 && !empty10) begin
                    coin_sel_d = SEL_10;
                    ack_tmr_d  = 8'd0;
                    state_d    = ST_REQ;
                end else if (remaining_q >= 8'd5 && !empty5) begin
                    coin_sel_d = SEL_5;
                    ack_tmr_d  = 8'd0;
                    state_d    = ST_REQ;
                end else if (!empty1) begin
                    coin_sel_d = SEL_1;
                    ack_tmr_d  = 8'd0;
                    state_d    = ST_REQ;
                end else begin
                    fault_code_d = FC_SHORTFALL;
                    state_d      = ST_FAULT;
                end
            end
            ST_REQ: begin
                // Ack has priority over a timeout in the same cycle.
                if (hopper_ack) begin
                    remaining_d = remaining_q - coin_value(coin_sel_q);
                    case (coin_sel_q)
                        SEL_10:  cnt10_d = cnt10_q + 8'd1;
                        SEL_5:   cnt5_d  = cnt5_q + 8'd1;
                        SEL_1:   cnt1_d  = cnt1_q + 8'd1;
                        default: cnt1_d  = cnt1_q;
                    endcase
                    state_d = ST_GAP;
                end else if (ack_tmr_q == 8'd255) begin
                    fault_code_d = FC_TIMEOUT;
                    state_d      = ST_FAULT;
                end else begin
                    ack_tmr_d = ack_tmr_q + 8'd1;
                    state_d   = ST_REQ;
                end
            end
            ST_GAP: begin
                state_d = ST_SELECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    fault_code_d = FC_NONE;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        coin_req_d = (state_d == ST_REQ);
        busy_d     = (state_d == ST_SELECT) || (state_d == ST_REQ) || (state_d == ST_GAP);
        done_d     = (state_d == ST_DONE);
        fault_d    = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ack_tmr_q    <= 8'd0;
            coin_req_q   <= 1'b0;
            coin_sel_q   <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'd0;
            remaining_q  <= 8'd0;
            cnt10_q      <= 8'd0;
            cnt5_q       <= 8'd0;
            cnt1_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            ack_tmr_q    <= ack_tmr_d;
            coin_req_q   <= coin_req_d;
            coin_sel_q   <= coin_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            remaining_q  <= remaining_d;
            cnt10_q      <= cnt10_d;
            cnt5_q       <= cnt5_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign coin_req   = coin_req_q;
    assign coin_sel   = coin_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign remaining  = remaining_q;
    assign cnt10      = cnt10_q;
    assign cnt5       = cnt5_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser. Inputs are driven and outputs
// sampled on the falling clock edge. Expected payouts come from a greedy
// division model (coins of 10, then 5, then 1, skipping empty tubes).
// ---------------------------------------------------------------------------
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] change_in;
    logic       empty10, empty5, empty1;
    logic       hopper_ack;
    logic       clear_fault;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy, done, fault;
    logic [1:0] fault_code;
    logic [7:0] remaining, cnt10, cnt5, cnt1;

    int total;
    int bad;

    change_dispenser dut (
        .clk(clk), .rst(rst), .start(start), .change_in(change_in),
        .empty10(empty10), .empty5(empty5), .empty1(empty1),
        .hopper_ack(hopper_ack), .clear_fault(clear_fault),
        .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy), .done(done),
        .fault(fault), .fault_code(fault_code), .remaining(remaining),
        .cnt10(cnt10), .cnt5(cnt5), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Greedy reference: how many of each coin and what is left over.
    function automatic void model(input int amt, input bit e10, input bit e5, input bit e1,
                                  output int n10, output int n5, output int n1, output int rem);
        rem = amt; n10 = 0; n5 = 0; n1 = 0;
        if (!e10) begin n10 = rem / 10; rem = rem % 10; end
        if (!e5)  begin n5  = rem / 5;  rem = rem % 5;  end
        if (!e1)  begin n1  = rem;      rem = 0;        end
    endfunction

    // Drives one payout as the hopper would; returns what was observed.
    // Called and returns on a falling edge; on return done or fault is high
    // (unless the cycle budget ran out).
    task automatic payout(input logic [7:0] amt, input logic e10, input logic e5, input logic e1,
                          input int dly, input bit drop10,
                          output int ndone, output int nfault, output int req_cycles,
                          output int gap_err, output int o10, output int o5, output int o1,
                          output int first_req, output int last_c);
        int run;
        bit acked;
        ndone = 0; nfault = 0; req_cycles = 0; gap_err = 0;
        o10 = 0; o5 = 0; o1 = 0; first_req = -1; last_c = -1;
        empty10 = e10; empty5 = e5; empty1 = e1;
        start = 1'b1; change_in = amt;
        @(negedge clk);
        start = 1'b0; change_in = 8'd0;
        run = 0; acked = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (acked && coin_req) gap_err++;
            acked = 1'b0;
            if (done)  ndone++;
            if (fault) nfault++;
            if (done || fault) begin
                last_c = c;
                break;
            end
            if (coin_req) begin
                if (first_req < 0) first_req = c;
                req_cycles++;
                if (drop10) empty10 = 1'b1;
                if (run == dly) begin
                    hopper_ack = 1'b1;
                    acked = 1'b1;
                    case (coin_sel)
                        2'd0: o1++;
                        2'd1: o5++;
                        2'd2: o10++;
                        default: gap_err++;
                    endcase
                end else begin
                    hopper_ack = 1'b0;
                end
                run++;
            end else begin
                hopper_ack = 1'b0;
                run = 0;
            end
            @(negedge clk);
        end
        hopper_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        rst = 1'b1; start = 1'b1; change_in = 8'd99; hopper_ack = 1'b1; clear_fault = 1'b1;
        empty10 = 1'b0; empty5 = 1'b0; empty1 = 1'b0;
        repeat (3) @(negedge clk);
        outs = {coin_req, coin_sel, busy, done, fault, fault_code, remaining, cnt10, cnt5, cnt1};
        total++;
        if (outs !== 40'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        rst = 1'b0; start = 1'b0; change_in = 8'd0; hopper_ack = 1'b0; clear_fault = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        payout(8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if (nd !== 1 || lc !== 0) begin
            bad++; $display("FAIL zero_done_latency got done=%0d at=%0d want 1 at 0", nd, lc);
        end
        total++;
        if (rq !== 0 || {cnt10, cnt5, cnt1} !== 24'd0) begin
            bad++; $display("FAIL zero_no_coins got req=%0d cnt=%h want 0", rq, {cnt10, cnt5, cnt1});
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL zero_done_width got=%b want=0", done);
        end
    endtask

    task automatic test_37();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        payout(8'd37, 1'b0, 1'b0, 1'b0, 1, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if ({cnt10, cnt5, cnt1} !== {8'd3, 8'd1, 8'd2} || remaining !== 8'd0) begin
            bad++; $display("FAIL pay37_counts got=%0d/%0d/%0d rem=%0d want 3/1/2 rem 0",
                            cnt10, cnt5, cnt1, remaining);
        end
        total++;
        if (nd !== 1 || nf !== 0 || fault !== 1'b0 || ge !== 0) begin
            bad++; $display("FAIL pay37_status got done=%0d fault=%0d gaperr=%0d want 1/0/0", nd, nf, ge);
        end
        total++;
        if (fr !== 1) begin
            bad++; $display("FAIL pay37_req_latency got=%0d want=1", fr);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL pay37_done_width got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_throughput();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        // 6 coins, immediate ack: REQ at 1,4,..,16, then GAP, SELECT, DONE at 19.
        payout(8'd37, 1'b0, 1'b0, 1'b0, 0, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if (lc !== 19 || rq !== 6 || ge !== 0) begin
            bad++; $display("FAIL throughput got done_at=%0d reqcyc=%0d gaperr=%0d want 19/6/0", lc, rq, ge);
        end
        @(negedge clk);
    endtask

    task automatic test_empty10();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        payout(8'd18, 1'b1, 1'b0, 1'b0, 1, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if ({cnt10, cnt5, cnt1} !== {8'd0, 8'd3, 8'd3} || nd !== 1) begin
            bad++; $display("FAIL pay18_no10 got=%0d/%0d/%0d done=%0d want 0/3/3 done 1",
                            cnt10, cnt5, cnt1, nd);
        end
        empty10 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty_in_flight();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        // empty10 rises while the 10-coin is being requested; it must still count.
        payout(8'd10, 1'b0, 1'b0, 1'b0, 2, 1'b1, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if (o10 !== 1 || cnt10 !== 8'd1 || remaining !== 8'd0 || nd !== 1) begin
            bad++; $display("FAIL in_flight got seen10=%0d cnt10=%0d rem=%0d done=%0d want 1/1/0/1",
                            o10, cnt10, remaining, nd);
        end
        empty10 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shortfall();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        payout(8'd7, 1'b0, 1'b1, 1'b1, 0, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if (nf !== 1 || fault_code !== 2'b01 || remaining !== 8'd7 || rq !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL shortfall got fault=%0d code=%b rem=%0d req=%0d busy=%b want 1/01/7/0/0",
                            nf, fault_code, remaining, rq, busy);
        end
        // start and hopper_ack are ignored in FAULT
        start = 1'b1; change_in = 8'd3; hopper_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; change_in = 8'd0; hopper_ack = 1'b0;
        @(negedge clk);
        total++;
        if (fault !== 1'b1 || remaining !== 8'd7 || coin_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fault_ignores_start got fault=%b rem=%0d req=%b busy=%b want 1/7/0/0",
                            fault, remaining, coin_req, busy);
        end
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        total++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || remaining !== 8'd7) begin
            bad++; $display("FAIL clear_fault got fault=%b code=%b rem=%0d want 0/00/7", fault, fault_code, remaining);
        end
        // hopper_ack in IDLE does nothing
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({cnt10, cnt5, cnt1} !== 24'd0 || coin_req !== 1'b0 || remaining !== 8'd7) begin
            bad++; $display("FAIL idle_ack_ignored got cnt=%h req=%b rem=%0d want 0/0/7",
                            {cnt10, cnt5, cnt1}, coin_req, remaining);
        end
        empty5 = 1'b0; empty1 = 1'b0;
    endtask

    task automatic test_timeout();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        payout(8'd10, 1'b0, 1'b0, 1'b0, 100000, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if (rq !== 256 || nf !== 1) begin
            bad++; $display("FAIL timeout_len got reqcyc=%0d fault=%0d want 256/1", rq, nf);
        end
        total++;
        if (fault_code !== 2'b10 || remaining !== 8'd10 || cnt10 !== 8'd0 || coin_req !== 1'b0) begin
            bad++; $display("FAIL timeout_state got code=%b rem=%0d cnt10=%0d req=%b want 10/10/0/0",
                            fault_code, remaining, cnt10, coin_req);
        end
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        int reqs;
        bit prev, hit;
        logic [39:0] outs;
        empty10 = 1'b0; empty5 = 1'b0; empty1 = 1'b0;
        start = 1'b1; change_in = 8'd25;
        @(negedge clk);
        start = 1'b0; change_in = 8'd0;
        reqs = 0; prev = 1'b0; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (coin_req && !prev) reqs++;
            prev = coin_req;
            if (reqs == 2 && coin_req) begin
                hopper_ack = 1'b1; rst = 1'b1; hit = 1'b1;
                break;
            end
            hopper_ack = coin_req;
            @(negedge clk);
        end
        @(negedge clk);
        outs = {coin_req, coin_sel, busy, done, fault, fault_code, remaining, cnt10, cnt5, cnt1};
        rst = 1'b0; hopper_ack = 1'b0;
        total++;
        if (!hit || outs !== 40'd0) begin
            bad++; $display("FAIL reset_mid_req got reached=%b outs=%h want 1/0", hit, outs);
        end
        payout(8'd5, 1'b0, 1'b0, 1'b0, 1, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
        total++;
        if ({cnt10, cnt5, cnt1} !== {8'd0, 8'd1, 8'd0} || nd !== 1) begin
            bad++; $display("FAIL after_reset_pay5 got=%0d/%0d/%0d done=%0d want 0/1/0 done 1",
                            cnt10, cnt5, cnt1, nd);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int nd, nf, rq, ge, o10, o5, o1, fr, lc;
        int m10, m5, m1, mrem, amt, dly;
        bit e10, e5, e1;
        for (int it = 0; it < 25; it++) begin
            amt = int'($urandom_range(0, 120));
            e10 = 1'($urandom_range(0, 1));
            e5  = 1'($urandom_range(0, 1));
            e1  = 1'($urandom_range(0, 1));
            dly = int'($urandom_range(0, 3));
            model(amt, e10, e5, e1, m10, m5, m1, mrem);
            payout(8'(amt), e10, e5, e1, dly, 1'b0, nd, nf, rq, ge, o10, o5, o1, fr, lc);
            total++;
            if (cnt10 !== 8'(m10) || cnt5 !== 8'(m5) || cnt1 !== 8'(m1) || remaining !== 8'(mrem)
                || o10 !== m10 || o5 !== m5 || o1 !== m1 || ge !== 0) begin
                bad++; $display("FAIL rand_counts it=%0d amt=%0d e=%b%b%b got=%0d/%0d/%0d rem=%0d want %0d/%0d/%0d rem %0d",
                                it, amt, e10, e5, e1, cnt10, cnt5, cnt1, remaining, m10, m5, m1, mrem);
            end
            total++;
            if ((mrem != 0) ? (nf !== 1 || fault_code !== 2'b01) : (nd !== 1 || fault !== 1'b0)) begin
                bad++; $display("FAIL rand_status it=%0d got done=%0d fault=%0d code=%b want shortfall=%0d",
                                it, nd, nf, fault_code, (mrem != 0));
            end
            if (fault) begin
                clear_fault = 1'b1;
                @(negedge clk);
                clear_fault = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; change_in = 8'd0; hopper_ack = 1'b0; clear_fault = 1'b0;
        empty10 = 1'b0; empty5 = 1'b0; empty1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_37();
        test_throughput();
        test_empty10();
        test_empty_in_flight();
        test_shortfall();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
